// File: rtl/uart_rx_pkg.sv
// Shared definitions for the aircraft-side serial receiver and the ATC controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: receiver state encoding, frame width, request-word field positions.
package bob_uart_pkg;

    localparam int FRAME_BITS = 9;

    // Request word layout, shared with the controller's request decoder.
    localparam int PLANE_ID_MSB = 8;
    localparam int PLANE_ID_LSB = 5;
    localparam int MSG_TYPE_MSB = 4;
    localparam int MSG_TYPE_LSB = 2;
    localparam int ACTION_MSB   = 1;
    localparam int ACTION_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, deserialised word plus status strobes out.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take every rx_valid strobe.
// master: the receiver (drives everything except rx_serial); slave: line driver / consumer.
// Optional macro UART_RX_PARITY_EN adds rx_parity_err.
interface uart_rx_if #(
    parameter int DATA_BITS = 9
);
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_framing_err;
    logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
    logic                 rx_parity_err;

    modport master (input rx_serial,
                    output rx_data, rx_valid, rx_framing_err, rx_busy, rx_parity_err);
    modport slave  (output rx_serial,
                    input rx_data, rx_valid, rx_framing_err, rx_busy, rx_parity_err);
`else
    modport master (input rx_serial,
                    output rx_data, rx_valid, rx_framing_err, rx_busy);
    modport slave  (output rx_serial,
                    input rx_data, rx_valid, rx_framing_err, rx_busy);
`endif
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter that paces the receiver's mid-bit sampling.
// Latency: done is high in the cycle the count reaches zero; a load takes effect next cycle.
// Backpressure: none.
// Ports: clock, reset_n, load/load_val (from FSM), done (to FSM).
module uart_bit_timer #(
    parameter int DIVISOR = 434,
    localparam int CW     = $clog2(DIVISOR)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 9-bit-frame UART receiver feeding the ATC controller's request FIFO.
// Latency: rx_valid 2 + DIVISOR/2 + (DATA_BITS+1)*DIVISOR + 1 cycles after the start edge (+DIVISOR with parity).
// Backpressure: none; every rx_valid strobe must be consumed.
// Ports: clock, reset_n, bus (uart_rx_if.master: rx_serial in; rx_data, rx_valid,
//        rx_framing_err, rx_busy [, rx_parity_err] out). Optional macro UART_RX_PARITY_EN.
module uart_rx
    import bob_uart_pkg::*;
#(
    parameter int DIVISOR   = 434,
    parameter int DATA_BITS = FRAME_BITS
) (
    input  logic     clock,
    input  logic     reset_n,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(DIVISOR);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 sync1;
    logic                 rx_s;
    logic [DATA_BITS-1:0] shreg;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 tmr_load;
    logic [CW-1:0]        tmr_val;
    logic                 tmr_done;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
    logic                 perr_q;
`endif

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.rx_serial;
            rx_s  <= sync1;
        end
    end

    uart_bit_timer #(.DIVISOR(DIVISOR)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Start edge loads half a bit so every later sample lands mid-bit;
    // each subsequent sample reloads a full bit period.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = FULL_LOAD;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LOAD;
                end
            end
            START:   tmr_load = tmr_done && !rx_s;
            DATA:    tmr_load = tmr_done;
            PARITY:  tmr_load = tmr_done;
            default: tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) state <= START;
                end
                START: begin
                    // A line that is high again at mid-start was a glitch.
                    if (tmr_done) begin
                        if (!rx_s) begin
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tmr_done) begin
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tmr_done) begin
                        // Even parity: payload ones plus parity bit must be even.
                        par_bad <= (^shreg) ^ rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tmr_done) begin
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                perr_q <= 1'b1;
                            end else begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shreg;
                            valid_q <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line recovers so a stuck-low line cannot retrigger.
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data        = data_q;
    assign bus.rx_valid       = valid_q;
    assign bus.rx_framing_err = ferr_q;
    assign bus.rx_busy        = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.rx_parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with DIVISOR=8 and randomized frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;
    localparam int D  = 8;
    localparam int NB = 9;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 2 + D / 2 + (NB + 1 + PB) * D + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    uart_rx_if #(.DATA_BITS(NB)) u_if ();

    uart_rx #(.DIVISOR(D), .DATA_BITS(NB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Observed events
    logic [NB-1:0] got_data[$];
    int            got_cyc[$];
    int            got_ferr = 0;
    int            got_perr = 0;
    int            overlap  = 0;
    int            busy_cnt = 0;
    // Reference model expectations
    logic [NB-1:0] exp_data[$];
    int            exp_cyc[$];
    int            exp_ferr = 0;
    int            exp_perr = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (u_if.rx_valid) begin
                got_data.push_back(u_if.rx_data);
                got_cyc.push_back(cyc);
            end
            if (u_if.rx_framing_err) got_ferr++;
            if (u_if.rx_valid && u_if.rx_framing_err) overlap++;
            if (u_if.rx_busy) busy_cnt++;
`ifdef UART_RX_PARITY_EN
            if (u_if.rx_parity_err) got_perr++;
            if (u_if.rx_valid && u_if.rx_parity_err) overlap++;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives one frame; the model expects a word only for a high stop bit
    // and (when parity is built in) a correct even parity bit.
    task automatic send_frame(input logic [NB-1:0] word, input logic stop_bit, input logic pflip);
        int st;
        st = cyc;
        u_if.rx_serial = 1'b0;
        tick(D);
        for (int i = 0; i < NB; i++) begin
            u_if.rx_serial = word[i];
            tick(D);
        end
`ifdef UART_RX_PARITY_EN
        u_if.rx_serial = (^word) ^ pflip;
        tick(D);
`endif
        u_if.rx_serial = stop_bit;
        tick(D);
        if (!stop_bit) begin
            exp_ferr++;
        end else if (PB == 1 && pflip) begin
            exp_perr++;
        end else begin
            exp_data.push_back(word);
            exp_cyc.push_back(st + LAT);
        end
    endtask

    task automatic check_batch(input string tag);
        int n;
        tick(5);
        check({tag, "_nvalid"}, got_data.size(), exp_data.size());
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, got_data[i], exp_data[i]);
            check({tag, "_lat"}, got_cyc[i], exp_cyc[i]);
        end
        check({tag, "_ferr"}, got_ferr, exp_ferr);
        check({tag, "_perr"}, got_perr, exp_perr);
        check({tag, "_overlap"}, overlap, 0);
        got_data.delete(); got_cyc.delete(); exp_data.delete(); exp_cyc.delete();
        got_ferr = 0; exp_ferr = 0; got_perr = 0; exp_perr = 0; overlap = 0;
    endtask

    initial begin
        logic [NB-1:0] w;
        logic          sb;
        logic          pf;

        u_if.rx_serial = 1'b1;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // Idle line after reset
        busy_cnt = 0;
        tick(100);
        check("idle_busy_cnt", busy_cnt, 0);
        check("idle_data", u_if.rx_data, 0);
        check_batch("idle");

        // Single frame with latency
        send_frame(9'h1A5, 1'b1, 1'b0);
        tick(2);
        check("f1a5_hold", u_if.rx_data, 9'h1A5);
        check_batch("f1a5");

        // Short low glitch
        busy_cnt = 0;
        u_if.rx_serial = 1'b0;
        tick(2);
        u_if.rx_serial = 1'b1;
        tick(6);
        check("glitch_busy_drop", u_if.rx_busy, 0);
        check("glitch_busy_seen", busy_cnt > 0, 1);
        tick(10);
        check_batch("glitch");

        // Stop bit low, line held low 40 cycles from stop start
        send_frame(9'h0F3, 1'b0, 1'b0);
        tick(40 - D);
        check("break_busy", u_if.rx_busy, 1);
        check("break_data_kept", u_if.rx_data, 9'h1A5);
        u_if.rx_serial = 1'b1;
        tick(6);
        check("break_exit", u_if.rx_busy, 0);
        send_frame(9'h011, 1'b1, 1'b0);
        check_batch("framing");

        // Back-to-back frames, zero idle gap
        send_frame(9'h100, 1'b1, 1'b0);
        send_frame(9'h0FF, 1'b1, 1'b0);
        check_batch("b2b");

        // Reset in the middle of data bit 4
        w = 9'h0AA;
        u_if.rx_serial = 1'b0;
        tick(D);
        for (int i = 0; i < 4; i++) begin
            u_if.rx_serial = w[i];
            tick(D);
        end
        u_if.rx_serial = w[4];
        tick(D / 2);
        reset_n = 1'b0;
        u_if.rx_serial = 1'b1;
        tick(3);
        check("rst_data", u_if.rx_data, 0);
        check("rst_busy", u_if.rx_busy, 0);
        reset_n = 1'b1;
        tick(20);
        check("rst_after_busy", u_if.rx_busy, 0);
        send_frame(9'h155, 1'b1, 1'b0);
        check_batch("midreset");

`ifdef UART_RX_PARITY_EN
        send_frame(9'h003, 1'b1, 1'b0);
        send_frame(9'h003, 1'b1, 1'b1);
        check_batch("parity");
`endif

        // Randomized frames against the model
        for (int k = 0; k < 14; k++) begin
            w  = NB'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pf = (PB == 1) && ($urandom_range(0, 4) == 0);
            send_frame(w, sb, pf);
            if (!sb) begin
                tick($urandom_range(0, 10));
                u_if.rx_serial = 1'b1;
                tick($urandom_range(4, 12));
            end else begin
                tick($urandom_range(0, 6));
            end
        end
        check_batch("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
